reg_file_sb: RTL and testbench

//  Parametrised multi-read-port register file with a write-to-read bypass and a pending-write scoreboard.

---
 rtl/reg_file_sb_pkg.sv | 30 +++
 rtl/reg_file_sb_if.sv | 51 +++++
 rtl/reg_file_sb_scoreboard.sv | 117 +++++++++++
 rtl/reg_file_sb.sv | 88 ++++++++
 tb/tb_reg_file_sb.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
//   Shared sizing helpers and default types for the ID-stage register file
//   with pending-write scoreboard (reg_file_sb).
//
//   Contents:
//     rf_aw(n)   address width needed for n architectural registers
//     rf_cw(n)   width of a counter that can hold 0..n
//     rf_addr_t  register address type for the default 32-entry file
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DATA_W_DEF   = 32;
    localparam int RF_NUM_REGS_DEF = 32;
    localparam int RF_NUM_RD_DEF   = 2;

    function automatic int rf_aw(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

    // pend_cnt has to represent "every register pending", hence n+1 values.
    function automatic int rf_cw(input int num_regs);
        return $clog2(num_regs + 1);
    endfunction

    localparam int RF_AW_DEF = rf_aw(RF_NUM_REGS_DEF);

    typedef logic [RF_AW_DEF-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
//   Bus bundle between the pipeline (master) and the register file /
//   scoreboard (slave).
//
//   Signals (master view):
//     rd_addr   out  NUM_RD*AW      read addresses, port p = [p*AW +: AW]
//     rd_data   in   NUM_RD*DATA_W  combinational read data
//     rd_busy   in   NUM_RD         port p's register has an outstanding write
//     wr_en     out  1              writeback valid
//     wr_addr   out  AW             writeback register
//     wr_data   out  DATA_W         writeback data
//     iss_en    out  1              request to mark iss_addr pending
//     iss_addr  out  AW             destination of the issuing instruction
//     iss_stall in   1              issue refused this cycle (WAW)
//     flush     out  1              clear all pending marks
//     pend_cnt  in   CW             number of pending registers
// ---------------------------------------------------------------------------
interface reg_file_sb_if
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int NUM_REGS = RF_NUM_REGS_DEF,
    parameter int NUM_RD   = RF_NUM_RD_DEF
);
    localparam int AW = rf_aw(NUM_REGS);
    localparam int CW = rf_cw(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     iss_stall;
    logic                     flush;
    logic [CW-1:0]            pend_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, iss_stall, pend_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, iss_stall, pend_cnt
    );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//   Pending-write tracker for the register file. Issue marks a destination
//   pending, writeback clears it, flush clears everything. Produces per-read
//   -port busy flags, the WAW issue stall and a live count of pending regs.
//
//   Ports:
//     clk, rst   clock / asynchronous active-low reset
//     rd_addr    in   NUM_RD*AW  read-port addresses
//     wr_en      in   1          writeback valid
//     wr_addr    in   AW         writeback register
//     iss_en     in   1          issue request
//     iss_addr   in   AW         issue destination
//     flush      in   1          clear all pending marks
//     rd_busy    out  NUM_RD     per-port outstanding-write flag
//     iss_stall  out  1          issue refused (WAW)
//     pend_cnt   out  CW         popcount of the pending vector
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = rf_aw(NUM_REGS),
    localparam int CW      = rf_cw(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 flush,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic                 iss_stall,
    output logic [CW-1:0]        pend_cnt
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pend_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;

    logic wr_ok;
    logic wr_pend;
    logic iss_ok;
    logic clr_iss;
    logic iss_pend;
    logic accept;

    // A register can carry a pending mark only if it exists and is not the
    // hard-wired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_ok    = wr_en && addr_ok(wr_addr);
    assign wr_pend  = wr_ok && pending[wr_addr];
    assign iss_ok   = addr_ok(iss_addr);

    // With the bypass, a writeback landing this cycle already resolves the
    // hazard, so the issuing instruction may take the register over.
    assign clr_iss  = BYPASS && wr_ok && (wr_addr == iss_addr);
    assign iss_pend = iss_ok && pending[iss_addr] && !clr_iss;

    assign iss_stall = rst && iss_en && !flush && iss_pend;
    assign accept    = iss_en && !flush && iss_ok && !iss_pend;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
        logic [AW-1:0] a;
        assign a          = rd_addr[p*AW +: AW];
        assign rd_busy[p] = rst && addr_ok(a) && pending[a] &&
                            !(BYPASS && wr_ok && (wr_addr == a));
    end

    // Priority: flush, then issue (set), then writeback (clear). The counter
    // follows the same decisions so it always equals popcount(pending):
    // +1 only when a clear register becomes pending, -1 only when a pending
    // register is cleared and not immediately re-issued.
    always_comb begin
        pend_nxt = pending;
        cnt_nxt  = cnt;
        if (flush) begin
            pend_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            if (wr_ok) begin
                pend_nxt[wr_addr] = 1'b0;
            end
            if (accept) begin
                pend_nxt[iss_addr] = 1'b1;
            end
            if (accept && !pending[iss_addr]) begin
                cnt_nxt = cnt_nxt + CW'(1);
            end
            if (wr_pend && !(accept && (iss_addr == wr_addr))) begin
                cnt_nxt = cnt_nxt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            cnt     <= '0;
        end else begin
            pending <= pend_nxt;
            cnt     <= cnt_nxt;
        end
    end

    assign pend_cnt = cnt;

endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//   ID-stage register file: NUM_RD combinational read ports with a
//   same-cycle write-to-read bypass, one writeback port, and a pending-write
//   scoreboard (rf_scoreboard) providing busy flags and the WAW stall.
//
//   Ports:
//     clk   in  1   clock, all state updates on the rising edge
//     rst   in  1   asynchronous active-low reset
//     bus   slave modport of reg_file_sb_if (read, write, issue, flush,
//           busy, stall and pend_cnt signals)
// ---------------------------------------------------------------------------
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic          clk,
    input logic          rst,
    reg_file_sb_if.slave bus
);

    localparam int AW = rf_aw(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

    assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < NUM_REGS) &&
                   !(ZERO_REG && (bus.wr_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read data is forced to zero while reset is asserted so the bypass
    // cannot leak writeback data onto the ports during reset.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     addr;
        logic              in_range;
        logic [DATA_W-1:0] word;

        assign addr     = bus.rd_addr[p*AW +: AW];
        assign in_range = 32'(addr) < NUM_REGS;

        always_comb begin
            word = '0;
            if (!rst || !in_range || (ZERO_REG && (addr == '0))) begin
                word = '0;
            end else if (BYPASS && bus.wr_en && (bus.wr_addr == addr)) begin
                word = bus.wr_data;
            end else begin
                word = regs[addr];
            end
        end

        assign bus.rd_data[p*DATA_W +: DATA_W] = word;
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (bus.rd_addr),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .iss_en    (bus.iss_en),
        .iss_addr  (bus.iss_addr),
        .flush     (bus.flush),
        .rd_busy   (bus.rd_busy),
        .iss_stall (bus.iss_stall),
        .pend_cnt  (bus.pend_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//   Self-checking bench for reg_file_sb (default parameters): a directed
//   vector table, reset sequences, and a randomised phase checked against a
//   behavioural model of the register file and scoreboard.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
    import rf_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = rf_aw(NR);
    localparam int CW  = rf_cw(NR);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

    reg_file_sb #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NRD),
        .ZERO_REG (1'b1),
        .BYPASS   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ie;
        logic [AW-1:0] ia;
        logic          fl;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
    } stim_t;

    typedef struct {
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic [1:0]    busy;
        logic          stall;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_pend;
    int            nvec = 0;
    int            nerr = 0;

    function automatic vec_t mk(input bit we, input int wa, input logic [DW-1:0] wd,
                                input bit ie, input int ia, input bit fl,
                                input int r0, input int r1,
                                input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                input logic [1:0] eb, input bit es, input int ec);
        vec_t v;
        v.s.we = we;       v.s.wa = AW'(wa);  v.s.wd = wd;
        v.s.ie = ie;       v.s.ia = AW'(ia);  v.s.fl = fl;
        v.s.ra0 = AW'(r0); v.s.ra1 = AW'(r1);
        v.e.rd0 = e0;      v.e.rd1 = e1;      v.e.busy = eb;
        v.e.stall = es;    v.e.cnt = CW'(ec);
        return v;
    endfunction

    function automatic stim_t idle(input int r0, input int r1);
        stim_t s;
        s.we = 1'b0; s.wa = '0; s.wd = '0;
        s.ie = 1'b0; s.ia = '0; s.fl = 1'b0;
        s.ra0 = AW'(r0); s.ra1 = AW'(r1);
        return s;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.rd0 = '0; e.rd1 = '0; e.busy = '0; e.stall = 1'b0; e.cnt = '0;
        return e;
    endfunction

    // Behavioural reference: outputs seen before the edge for stimulus s.
    function automatic logic [DW-1:0] m_read(input stim_t s, input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (s.we && s.wa == a) return s.wd;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input stim_t s, input logic [AW-1:0] a);
        return m_pend[a] && !(s.we && s.wa == a);
    endfunction

    function automatic logic m_stall(input stim_t s);
        return s.ie && !s.fl && m_pend[s.ia] && !(s.we && s.wa == s.ia);
    endfunction

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        e.rd0   = m_read(s, s.ra0);
        e.rd1   = m_read(s, s.ra1);
        e.busy  = {m_busy(s, s.ra1), m_busy(s, s.ra0)};
        e.stall = m_stall(s);
        e.cnt   = CW'($countones(m_pend));
        return e;
    endfunction

    task automatic model_step(input stim_t s);
        logic st;
        st = m_stall(s);
        if (s.we && s.wa != '0) m_regs[s.wa] = s.wd;
        if (s.fl) begin
            m_pend = '0;
        end else begin
            if (s.we && s.wa != '0) m_pend[s.wa] = 1'b0;
            if (s.ie && !st && s.ia != '0) m_pend[s.ia] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        m_pend = '0;
    endtask

    task automatic apply(input stim_t s);
        bus.wr_en    = s.we;
        bus.wr_addr  = s.wa;
        bus.wr_data  = s.wd;
        bus.iss_en   = s.ie;
        bus.iss_addr = s.ia;
        bus.flush    = s.fl;
        bus.rd_addr  = {s.ra1, s.ra0};
    endtask

    task automatic check(input string name);
        exp_t e;
        nvec++;
        if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL %s: scoreboard queue empty", name);
            return;
        end
        e = exp_q.pop_front();
        if (bus.rd_data[DW-1:0] !== e.rd0) begin
            nerr++;
            $display("FAIL %s rd_data0: got %h want %h", name, bus.rd_data[DW-1:0], e.rd0);
        end
        if (bus.rd_data[2*DW-1:DW] !== e.rd1) begin
            nerr++;
            $display("FAIL %s rd_data1: got %h want %h", name, bus.rd_data[2*DW-1:DW], e.rd1);
        end
        if (bus.rd_busy !== e.busy) begin
            nerr++;
            $display("FAIL %s rd_busy: got %b want %b", name, bus.rd_busy, e.busy);
        end
        if (bus.iss_stall !== e.stall) begin
            nerr++;
            $display("FAIL %s iss_stall: got %b want %b", name, bus.iss_stall, e.stall);
        end
        if (bus.pend_cnt !== e.cnt) begin
            nerr++;
            $display("FAIL %s pend_cnt: got %0d want %0d", name, bus.pend_cnt, e.cnt);
        end
    endtask

    // One clock: drive after the edge, sample on the falling edge, then
    // advance the model to match what the DUT will do on the next edge.
    task automatic run_cycle(input stim_t s, input exp_t e_in, input bit use_model,
                             input string name);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e = use_model ? model_out(s) : e_in;
        exp_q.push_back(e);
        @(negedge clk);
        check(name);
        model_step(s);
    endtask

    vec_t  vt [21];
    stim_t s;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 0, 32'hDEADBEEF, 32'h0, 2'b00, 0, 0);
        vt[1]  = mk(0, 0, 32'h0,        0, 0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 0);
        vt[2]  = mk(1, 0, 32'h1234,     1, 0, 0, 0, 7, 32'h0, 32'hDEADBEEF, 2'b00, 0, 0);
        vt[3]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 0);
        vt[4]  = mk(0, 0, 32'h0,        1, 3, 0, 3, 7, 32'h0, 32'hDEADBEEF, 2'b00, 0, 0);
        vt[5]  = mk(0, 0, 32'h0,        1, 3, 0, 3, 7, 32'h0, 32'hDEADBEEF, 2'b01, 1, 1);
        vt[6]  = mk(1, 3, 32'h33,       1, 3, 0, 3, 3, 32'h33, 32'h33, 2'b00, 0, 1);
        vt[7]  = mk(0, 0, 32'h0,        0, 0, 0, 3, 7, 32'h33, 32'hDEADBEEF, 2'b01, 0, 1);
        vt[8]  = mk(1, 3, 32'h44,       0, 0, 0, 3, 3, 32'h44, 32'h44, 2'b00, 0, 1);
        vt[9]  = mk(0, 0, 32'h0,        1, 1, 0, 3, 1, 32'h44, 32'h0, 2'b00, 0, 0);
        vt[10] = mk(0, 0, 32'h0,        1, 2, 0, 1, 2, 32'h0, 32'h0, 2'b01, 0, 1);
        vt[11] = mk(0, 0, 32'h0,        1, 4, 0, 1, 2, 32'h0, 32'h0, 2'b11, 0, 2);
        vt[12] = mk(0, 0, 32'h0,        1, 9, 1, 4, 9, 32'h0, 32'h0, 2'b01, 0, 3);
        vt[13] = mk(0, 0, 32'h0,        0, 0, 0, 4, 9, 32'h0, 32'h0, 2'b00, 0, 0);
        vt[14] = mk(1, 9, 32'h99,       0, 0, 0, 9, 2, 32'h99, 32'h0, 2'b00, 0, 0);
        vt[15] = mk(0, 0, 32'h0,        1, 5, 0, 5, 9, 32'h0, 32'h99, 2'b00, 0, 0);
        vt[16] = mk(1, 5, 32'h55,       0, 0, 0, 5, 9, 32'h55, 32'h99, 2'b00, 0, 1);
        vt[17] = mk(0, 0, 32'h0,        0, 0, 0, 5, 9, 32'h55, 32'h99, 2'b00, 0, 0);
        vt[18] = mk(0, 0, 32'h0,        1, 6, 0, 6, 5, 32'h0, 32'h55, 2'b00, 0, 0);
        vt[19] = mk(1, 5, 32'h66,       1, 6, 0, 6, 5, 32'h0, 32'h66, 2'b01, 1, 1);
        vt[20] = mk(0, 0, 32'h0,        0, 0, 0, 6, 5, 32'h0, 32'h66, 2'b01, 0, 1);

        // Power-on reset with a write and an issue pending on the bus.
        rst = 1'b0;
        s = idle(5, 6);
        s.we = 1'b1; s.wa = AW'(5); s.wd = 32'hCAFEF00D;
        s.ie = 1'b1; s.ia = AW'(6);
        apply(s);
        model_reset();
        repeat (2) @(posedge clk);
        exp_q.push_back(zero_exp());
        @(negedge clk);
        check("por");
        apply(idle(0, 0));
        rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            run_cycle(vt[i].s, vt[i].e, 1'b0, $sformatf("vec%0d", i));
        end

        // Reset asserted in the middle of a write and an issue.
        @(posedge clk);
        #1;
        s = idle(5, 6);
        s.we = 1'b1; s.wa = AW'(5); s.wd = 32'hA5A5A5A5;
        s.ie = 1'b1; s.ia = AW'(8);
        apply(s);
        #1 rst = 1'b0;
        exp_q.push_back(zero_exp());
        @(negedge clk);
        check("rst_mid");
        @(posedge clk);
        #1;
        apply(idle(5, 6));
        exp_q.push_back(zero_exp());
        @(negedge clk);
        check("rst_hold");
        rst = 1'b1;
        model_reset();
        run_cycle(idle(5, 6), zero_exp(), 1'b1, "rst_after");

        for (int c = 0; c < 10000; c++) begin
            s.we  = ($urandom_range(0, 1) == 1);
            s.wa  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, NR - 1))
                                                : AW'($urandom_range(0, 7));
            s.wd  = $urandom;
            s.ie  = ($urandom_range(0, 1) == 1);
            s.ia  = AW'($urandom_range(0, 7));
            s.fl  = ($urandom_range(0, 31) == 0);
            s.ra0 = AW'($urandom_range(0, 7));
            s.ra1 = AW'($urandom_range(0, 7));
            run_cycle(s, zero_exp(), 1'b1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
